// File: rtl/clock_mode_seq.sv
// Mode sequencer for the min:sec clock/alarm: debounces buttons, runs the 1 s time base and
// steps CLOCK / SETUP / ALARM-set / RING, emitting one-cycle increment enables on a single clock.
module clock_mode_seq #(
  parameter int unsigned TICK_CYC      = 50000000,
  parameter int unsigned DEB_CYC       = 1000000,
  parameter int unsigned LONG_CYC      = 50000000,
  parameter int unsigned REP_CYC       = 10000000,
  parameter int unsigned TIMEOUT_TICKS = 30,
  parameter int unsigned RING_TICKS    = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] i_sw,
  input  logic       i_alarm_match,
  output logic [1:0] o_mode,
  output logic       o_position,
  output logic       o_alarm_en,
  output logic       o_sec_inc,
  output logic       o_min_inc,
  output logic       o_carry_en,
  output logic       o_alm_sec_inc,
  output logic       o_alm_min_inc,
  output logic       o_ring
);

  localparam int unsigned TickW = $clog2(TICK_CYC);
  localparam int unsigned DebW  = $clog2(DEB_CYC + 1);
  localparam int unsigned HoldW = $clog2(LONG_CYC + 1);
  localparam int unsigned IdleW = $clog2(TIMEOUT_TICKS + 1);
  localparam int unsigned RingW = $clog2(RING_TICKS + 1);

  typedef enum logic [2:0] {StClock, StSetSec, StSetMin, StAlmSec, StAlmMin, StRing} state_e;

  state_e state_q, state_d;

  logic [3:0]      sw_meta_q, sw_sync_q, deb_q, deb_d, press;
  logic [DebW-1:0] deb_cnt_q [4];
  logic [DebW-1:0] deb_cnt_d [4];
  logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [IdleW-1:0] idle_q, idle_d;
  logic [RingW-1:0] ring_cnt_q, ring_cnt_d;
  logic tick, rep, inc, inc_ok, any_press, in_set_alm, timeout, ring_done, ring_start;
  logic match_q, alarm_en_q, alarm_en_d;
  logic [1:0] mode_q, mode_d;
  logic position_q, position_d, carry_en_q, carry_en_d, ring_q, ring_d;
  logic sec_inc_q, sec_inc_d, min_inc_q, min_inc_d;
  logic alm_sec_inc_q, alm_sec_inc_d, alm_min_inc_q, alm_min_inc_d;

  // Debounce: level follows the synchronised input only after DEB_CYC differing cycles in a row.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      deb_d[i]     = deb_q[i];
      deb_cnt_d[i] = '0;
      if (sw_sync_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == DebW'(DEB_CYC - 1)) begin
          deb_d[i] = sw_sync_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
        end
      end
    end
    press     = deb_q & ~deb_d;
    any_press = |press;
  end

  always_comb begin
    tick       = (tick_cnt_q == TickW'(TICK_CYC - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    // Hold counter is 0 on the first held cycle; reload keeps later reps REP_CYC apart.
    rep = ~deb_q[2] && (hold_q == HoldW'(LONG_CYC));
    if (deb_q[2]) begin
      hold_d = '0;
    end else if (rep) begin
      hold_d = HoldW'(LONG_CYC - REP_CYC + 1);
    end else begin
      hold_d = hold_q + 1'b1;
    end
    inc        = press[2] | rep;
    inc_ok     = inc & ~press[0] & ~press[1];
    ring_start = alarm_en_q & i_alarm_match & ~match_q;
  end

  always_comb begin
    in_set_alm = (state_q == StSetSec) || (state_q == StSetMin) ||
                 (state_q == StAlmSec) || (state_q == StAlmMin);
    idle_d  = '0;
    timeout = 1'b0;
    if (in_set_alm && !any_press && !rep) begin
      idle_d = idle_q;
      if (tick) begin
        if (idle_q == IdleW'(TIMEOUT_TICKS - 1)) timeout = 1'b1;
        else                                     idle_d  = idle_q + 1'b1;
      end
    end
    ring_cnt_d = '0;
    ring_done  = 1'b0;
    if (state_q == StRing) begin
      ring_cnt_d = ring_cnt_q;
      if (tick) begin
        if (ring_cnt_q == RingW'(RING_TICKS - 1)) ring_done  = 1'b1;
        else                                      ring_cnt_d = ring_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StClock: begin
        if (press[0])        state_d = StSetSec;
        else if (ring_start) state_d = StRing;
      end
      StSetSec: begin
        if (press[0])      state_d = StAlmSec;
        else if (press[1]) state_d = StSetMin;
        else if (timeout)  state_d = StClock;
      end
      StSetMin: begin
        if (press[0])      state_d = StAlmSec;
        else if (press[1]) state_d = StSetSec;
        else if (timeout)  state_d = StClock;
      end
      StAlmSec: begin
        if (press[0])      state_d = StClock;
        else if (press[1]) state_d = StAlmMin;
        else if (timeout)  state_d = StClock;
      end
      StAlmMin: begin
        if (press[0])      state_d = StClock;
        else if (press[1]) state_d = StAlmSec;
        else if (timeout)  state_d = StClock;
      end
      StRing: begin
        if (any_press || ring_done) state_d = StClock;
      end
      default: state_d = StClock;
    endcase
  end

  always_comb begin
    sec_inc_d     = 1'b0;
    min_inc_d     = 1'b0;
    alm_sec_inc_d = 1'b0;
    alm_min_inc_d = 1'b0;
    unique case (state_q)
      StSetSec: sec_inc_d = inc_ok;
      StSetMin: min_inc_d = inc_ok;
      StAlmSec: begin
        sec_inc_d     = tick;
        alm_sec_inc_d = inc_ok;
      end
      StAlmMin: begin
        sec_inc_d     = tick;
        alm_min_inc_d = inc_ok;
      end
      default: sec_inc_d = tick;
    endcase
    mode_d     = 2'b00;
    position_d = 1'b0;
    carry_en_d = 1'b1;
    unique case (state_d)
      StSetSec: begin
        mode_d     = 2'b01;
        carry_en_d = 1'b0;
      end
      StSetMin: begin
        mode_d     = 2'b01;
        position_d = 1'b1;
        carry_en_d = 1'b0;
      end
      StAlmSec: mode_d = 2'b10;
      StAlmMin: begin
        mode_d     = 2'b10;
        position_d = 1'b1;
      end
      default: mode_d = 2'b00;
    endcase
    ring_d     = (state_d == StRing);
    alarm_en_d = alarm_en_q ^ (press[3] && (state_q != StRing));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StClock;
      sw_meta_q     <= 4'hF;
      sw_sync_q     <= 4'hF;
      deb_q         <= 4'hF;
      for (int i = 0; i < 4; i++) deb_cnt_q[i] <= '0;
      tick_cnt_q    <= '0;
      hold_q        <= '0;
      idle_q        <= '0;
      ring_cnt_q    <= '0;
      match_q       <= 1'b0;
      alarm_en_q    <= 1'b0;
      mode_q        <= 2'b00;
      position_q    <= 1'b0;
      carry_en_q    <= 1'b0;
      ring_q        <= 1'b0;
      sec_inc_q     <= 1'b0;
      min_inc_q     <= 1'b0;
      alm_sec_inc_q <= 1'b0;
      alm_min_inc_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sw_meta_q     <= i_sw;
      sw_sync_q     <= sw_meta_q;
      deb_q         <= deb_d;
      for (int i = 0; i < 4; i++) deb_cnt_q[i] <= deb_cnt_d[i];
      tick_cnt_q    <= tick_cnt_d;
      hold_q        <= hold_d;
      idle_q        <= idle_d;
      ring_cnt_q    <= ring_cnt_d;
      match_q       <= i_alarm_match;
      alarm_en_q    <= alarm_en_d;
      mode_q        <= mode_d;
      position_q    <= position_d;
      carry_en_q    <= carry_en_d;
      ring_q        <= ring_d;
      sec_inc_q     <= sec_inc_d;
      min_inc_q     <= min_inc_d;
      alm_sec_inc_q <= alm_sec_inc_d;
      alm_min_inc_q <= alm_min_inc_d;
    end
  end

  assign o_mode        = mode_q;
  assign o_position    = position_q;
  assign o_alarm_en    = alarm_en_q;
  assign o_sec_inc     = sec_inc_q;
  assign o_min_inc     = min_inc_q;
  assign o_carry_en    = carry_en_q;
  assign o_alm_sec_inc = alm_sec_inc_q;
  assign o_alm_min_inc = alm_min_inc_q;
  assign o_ring        = ring_q;

endmodule

// File: tb/tb_clock_mode_seq.sv
// Directed bench for clock_mode_seq with shortened timing parameters.
module tb_clock_mode_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sw;
  logic       match;
  logic [1:0] o_mode;
  logic o_position, o_alarm_en, o_sec_inc, o_min_inc, o_carry_en;
  logic o_alm_sec_inc, o_alm_min_inc, o_ring;

  int n_checks = 0;
  int n_fail   = 0;
  int n_sec = 0, n_min = 0, n_asec = 0, n_wide = 0;
  logic [3:0] prev_en = '0;

  clock_mode_seq #(
    .TICK_CYC(10), .DEB_CYC(4), .LONG_CYC(20), .REP_CYC(5), .TIMEOUT_TICKS(3), .RING_TICKS(5)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_sw         (sw),
    .i_alarm_match(match),
    .o_mode       (o_mode),
    .o_position   (o_position),
    .o_alarm_en   (o_alarm_en),
    .o_sec_inc    (o_sec_inc),
    .o_min_inc    (o_min_inc),
    .o_carry_en   (o_carry_en),
    .o_alm_sec_inc(o_alm_sec_inc),
    .o_alm_min_inc(o_alm_min_inc),
    .o_ring       (o_ring)
  );

  always #5 clk = ~clk;

  // Pulse counters and width watch, sampled on the falling edge.
  always @(negedge clk) begin
    if (o_sec_inc)     n_sec  <= n_sec + 1;
    if (o_min_inc)     n_min  <= n_min + 1;
    if (o_alm_sec_inc) n_asec <= n_asec + 1;
    if (({o_sec_inc, o_min_inc, o_alm_sec_inc, o_alm_min_inc} & prev_en) != 4'b0)
      n_wide <= n_wide + 1;
    prev_en <= {o_sec_inc, o_min_inc, o_alm_sec_inc, o_alm_min_inc};
  end

  task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic press_btn(input int idx);
    sw[idx] = 1'b0;
    step(7);
    sw[idx] = 1'b1;
    step(7);
  endtask

  function automatic int unsigned all_outs();
    return {22'd0, o_mode, o_position, o_alarm_en, o_sec_inc, o_min_inc, o_carry_en,
            o_alm_sec_inc, o_alm_min_inc, o_ring};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first, last, np, gap_bad, n, s0, s_min, s_a, s_sec;
    int t[$];
    bit bounce[5];
    bounce = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    sw = 4'hF; match = 1'b0; rst_n = 1'b0;
    step(3);
    check_eq("reset_outputs", all_outs(), 0);
    rst_n = 1'b1;

    // 1: free-running tick
    first = -1; last = -1; np = 0; gap_bad = 0;
    for (int c = 1; c <= 100; c++) begin
      step(1);
      if (o_sec_inc) begin
        if (first < 0) first = c;
        else if (c - last != 10) gap_bad++;
        last = c;
        np++;
      end
    end
    check_eq("t1_pulses", np, 10);
    check_eq("t1_first", first, 10);
    check_eq("t1_gap", gap_bad, 0);
    check_eq("t1_mode", o_mode, 0);
    check_eq("t1_carry", o_carry_en, 1);

    // 2: bouncing sw0, then held
    foreach (bounce[i]) begin
      sw[0] = bounce[i];
      step(1);
    end
    step(4);
    check_eq("t2_mode_before", o_mode, 0);
    step(1);
    check_eq("t2_mode_after", o_mode, 1);
    s0 = n_sec;
    step(3);
    check_eq("t2_single_step", o_mode, 1);
    sw[0] = 1'b1;
    step(6);
    check_eq("t2_sec_frozen", n_sec - s0, 0);
    check_eq("t2_carry", o_carry_en, 0);
    check_eq("t2_position", o_position, 0);

    // 3: SET_MIN auto-repeat
    sw[1] = 1'b0;
    n = 0;
    while (!o_position && n < 10) begin
      step(1);
      n++;
    end
    check_eq("t3_set_min", {o_mode, o_position}, 3'b011);
    sw[1] = 1'b1; sw[2] = 1'b0;
    s_min = n_min;
    for (int c = 1; c <= 48; c++) begin
      if (c == 41) sw[2] = 1'b1;
      step(1);
      if (o_min_inc) t.push_back(c);
    end
    check_eq("t3_min_pulses", n_min - s_min, 5);
    check_eq("t3_count", t.size(), 5);
    if (t.size() == 5) begin
      check_eq("t3_first_rep_gap", t[1] - t[0], 21);
      check_eq("t3_rep_span", t[4] - t[1], 15);
    end
    check_eq("t3_sec_frozen", n_sec - s0, 0);

    // 4: ALM_SEC, two increments, then timeout
    press_btn(0);
    check_eq("t4_alm_mode", {o_mode, o_position}, 3'b100);
    s_a = n_asec; s_sec = n_sec;
    press_btn(2);
    press_btn(2);
    check_eq("t4_alm_sec_pulses", n_asec - s_a, 2);
    check_eq("t4_time_runs", (n_sec - s_sec) >= 1, 1);
    step(8);
    check_eq("t4_no_early_timeout", o_mode, 2);
    n = 0;
    while (o_mode != 2'b00 && n < 30) begin
      step(1);
      n++;
    end
    check_eq("t4_timeout_mode", o_mode, 0);
    check_eq("t4_alarm_en", o_alarm_en, 0);

    // 5: ring by timeout, then ring dismissed by sw3
    press_btn(3);
    check_eq("t5_armed", o_alarm_en, 1);
    match = 1'b1;
    step(1);
    check_eq("t5_ring_on", o_ring, 1);
    n = 0;
    while (o_ring && n < 70) begin
      step(1);
      n++;
    end
    check_eq("t5_ring_len_ok", (n >= 41 && n <= 50), 1);
    check_eq("t5_alarm_kept", o_alarm_en, 1);
    step(15);
    check_eq("t5_no_retrigger", o_ring, 0);
    match = 1'b0;
    step(2);
    match = 1'b1;
    step(1);
    check_eq("t5_ring_again", o_ring, 1);
    press_btn(3);
    check_eq("t5_dismissed", o_ring, 0);
    check_eq("t5_alarm_unchanged", o_alarm_en, 1);
    check_eq("t5_mode", o_mode, 0);

    // 6: same-cycle sw0+sw1, masked match, async reset in RING
    match = 1'b0;
    press_btn(0);
    check_eq("t6_set_sec", {o_mode, o_position}, 3'b010);
    sw[0] = 1'b0; sw[1] = 1'b0;
    step(7);
    sw[0] = 1'b1; sw[1] = 1'b1;
    step(7);
    check_eq("t6_priority", {o_mode, o_position}, 3'b100);
    match = 1'b1;
    step(2);
    check_eq("t6_match_ignored", o_ring, 0);
    press_btn(0);
    check_eq("t6_no_queue", {o_mode, o_ring}, 3'b000);
    match = 1'b0;
    step(1);
    match = 1'b1;
    step(1);
    check_eq("t6_ring", o_ring, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_async_ring", o_ring, 0);
    check_eq("t6_async_outs", all_outs(), 0);
    step(2);
    rst_n = 1'b1;
    step(3);
    check_eq("t6_post_reset", {o_mode, o_ring, o_alarm_en, o_carry_en}, 5'b00001);

    check_eq("no_wide_pulses", n_wide, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
